// File: rtl/mem_stage_if.sv
// Signal bundle between the execute/stall-control side and the memory-access stage.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 82
);
    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [1:0]              ex_addr_lo;
    logic [31:0]             data_sram_rdata;
    logic                    data_sram_rvalid;
    logic [69:0]             mem_to_wb_bus;
    logic [37:0]             mem_to_rf_bus;
    logic                    stallreq_mem;
    logic                    mem_adel;
    logic                    mem_timeout;

    modport master (
        output stall, ex_to_mem_bus, ex_addr_lo, data_sram_rdata, data_sram_rvalid,
        input  mem_to_wb_bus, mem_to_rf_bus, stallreq_mem, mem_adel, mem_timeout
    );

    modport slave (
        input  stall, ex_to_mem_bus, ex_addr_lo, data_sram_rdata, data_sram_rvalid,
        output mem_to_wb_bus, mem_to_rf_bus, stallreq_mem, mem_adel, mem_timeout
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, waits for the SRAM
// read response, aligns/extends load data and drives writeback and forwarding buses.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 82,
    parameter int WAIT_MAX     = 15
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave mem_if
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [3:0] L_WAIT_MAX = 4'(WAIT_MAX);

    function automatic logic f_is_load(input logic en, input logic [3:0] wen, input logic [5:0] op);
        return en && (wen == 4'b0000) &&
               (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
    endfunction

    logic [EX_TO_MEM_WD-1:0] r_bus;
    logic [1:0]              r_addr_lo;
    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [31:0]             r_cap;
    logic                    r_timeout;

    logic                    w_bubble;
    logic                    w_load;
    logic [EX_TO_MEM_WD-1:0] w_next_bus;
    logic [1:0]              w_next_lo;
    logic                    w_next_is_load;
    state_t                  w_state_nx;
    logic [3:0]              w_cnt_nx;
    logic [31:0]             w_cap_nx;
    logic                    w_timeout_nx;

    logic [31:0] w_pc;
    logic        w_en;
    logic [3:0]  w_wen;
    logic        w_sel;
    logic        w_we_in;
    logic [4:0]  w_waddr;
    logic [5:0]  w_op;
    logic [31:0] w_res;
    logic        w_is_load;
    logic        w_in_wait;
    logic        w_stall_req;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;
    logic        w_adel;
    logic        w_we;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_unused = ^{mem_if.stall[5], mem_if.stall[2:0]};

    // A bubble is inserted when this stage stops but writeback keeps going.
    assign w_bubble   = mem_if.stall[3] & ~mem_if.stall[4];
    assign w_load     = ~mem_if.stall[3] | w_bubble;
    assign w_next_bus = w_bubble ? '0 : mem_if.ex_to_mem_bus;
    assign w_next_lo  = w_bubble ? '0 : mem_if.ex_addr_lo;
    assign w_next_is_load = f_is_load(w_next_bus[49], w_next_bus[48:45], w_next_bus[37:32]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus     <= '0;
            r_addr_lo <= '0;
        end else if (w_load) begin
            r_bus     <= w_next_bus;
            r_addr_lo <= w_next_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cap     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_cap     <= w_cap_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_cap_nx     = r_cap;
        w_timeout_nx = r_timeout;
        if (w_load) begin
            w_state_nx = w_next_is_load ? S_WAIT : S_IDLE;
            w_cnt_nx   = '0;
            w_cap_nx   = '0;
        end else if (r_state == S_WAIT) begin
            if (mem_if.data_sram_rvalid) begin
                w_state_nx = S_DONE;
                w_cap_nx   = mem_if.data_sram_rdata;
            end else begin
                w_cnt_nx = r_cnt + 4'd1;
                if (w_cnt_nx == L_WAIT_MAX) begin
                    w_state_nx   = S_DONE;
                    w_cap_nx     = '0;
                    w_timeout_nx = 1'b1;
                end
            end
        end
    end

    assign w_pc    = r_bus[81:50];
    assign w_en    = r_bus[49];
    assign w_wen   = r_bus[48:45];
    assign w_sel   = r_bus[44];
    assign w_we_in = r_bus[43];
    assign w_waddr = r_bus[42:38];
    assign w_op    = r_bus[37:32];
    assign w_res   = r_bus[31:0];

    assign w_is_load   = f_is_load(w_en, w_wen, w_op);
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_stall_req = w_in_wait & ~mem_if.data_sram_rvalid;
    // A same-cycle response bypasses the capture register.
    assign w_raw       = (w_in_wait & mem_if.data_sram_rvalid) ? mem_if.data_sram_rdata : r_cap;
    assign w_byte      = w_raw[{r_addr_lo, 3'b000} +: 8];
    assign w_half      = r_addr_lo[1] ? w_raw[31:16] : w_raw[15:0];

    always_comb begin
        w_ld = w_raw;
        case (w_op)
            OP_LB:   w_ld = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ld = {24'b0, w_byte};
            OP_LH:   w_ld = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ld = {16'b0, w_half};
            default: w_ld = w_raw;
        endcase
    end

    assign w_adel  = w_is_load &
                     ((((w_op == OP_LH) || (w_op == OP_LHU)) & r_addr_lo[0]) |
                      ((w_op == OP_LW) & (r_addr_lo != 2'b00)));
    assign w_we    = w_we_in & ~w_adel & ~w_stall_req;
    assign w_wdata = (w_sel & w_is_load) ? w_ld : w_res;

    assign mem_if.mem_to_wb_bus = {w_pc, w_we, w_waddr, w_wdata};
    assign mem_if.mem_to_rf_bus = {w_we, w_waddr, w_wdata};
    assign mem_if.stallreq_mem  = w_stall_req;
    assign mem_if.mem_adel      = w_adel;
    assign mem_if.mem_timeout   = r_timeout;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference model predicts each instruction's
// writeback result when issued; a negedge monitor checks it when it leaves the stage.
module tb_mem_stage;
    localparam int WAIT_MAX = 15;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] ST_HOLD = 6'b011111;
    localparam logic [5:0] ST_BUB  = 6'b001111;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  wa;
        logic [5:0]  op;
        logic [31:0] res;
        logic [1:0]  lo;
        logic [31:0] rdata;
        int          d;
        int          hold;
    } instr_t;

    typedef struct {
        logic [69:0] wb;
        logic        adel;
        logic        tmo;
        int          nstall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.EX_TO_MEM_WD(82)) m_if ();
    mem_stage #(.EX_TO_MEM_WD(82), .WAIT_MAX(WAIT_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (m_if)
    );

    int     total = 0;
    int     bad = 0;
    instr_t pend[$];
    exp_t   sb[$];
    logic   sb_tmo = 1'b0;
    int     stall_cnt = 0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic m_is_load(input instr_t i);
        return i.en && i.wen == 4'd0 &&
               (i.op == OP_LB || i.op == OP_LH || i.op == OP_LW || i.op == OP_LBU || i.op == OP_LHU);
    endfunction

    function automatic logic [31:0] m_extract(input logic [5:0] op, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * int'(lo));
        h = w >> (16 * int'(lo[1]));
        case (op)
            OP_LB:   return {{24{b[7]}}, b[7:0]};
            OP_LBU:  return {24'd0, b[7:0]};
            OP_LH:   return {{16{h[15]}}, h[15:0]};
            OP_LHU:  return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic exp_t m_expect(input instr_t i);
        exp_t e;
        logic ld, adel, resp;
        logic [31:0] raw, wd;
        ld   = m_is_load(i);
        resp = i.d < WAIT_MAX;
        raw  = resp ? i.rdata : 32'd0;
        adel = ld && (((i.op == OP_LH || i.op == OP_LHU) && i.lo[0]) || (i.op == OP_LW && i.lo != 2'd0));
        wd   = (ld && i.sel) ? m_extract(i.op, i.lo, raw) : i.res;
        e.wb     = {i.pc, i.we & ~adel, i.wa, wd};
        e.adel   = adel;
        e.tmo    = 1'b0;
        e.nstall = ld ? (resp ? i.d : WAIT_MAX) : 0;
        return e;
    endfunction

    function automatic logic [81:0] pack(input instr_t i);
        return {i.pc, i.en, i.wen, i.sel, i.we, i.wa, i.op, i.res};
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                  input logic sel, input logic we, input logic [4:0] wa,
                                  input logic [5:0] op, input logic [31:0] res, input logic [1:0] lo,
                                  input logic [31:0] rdata, input int d, input int hold);
        instr_t i;
        i.pc = pc; i.en = en; i.wen = wen; i.sel = sel; i.we = we; i.wa = wa;
        i.op = op; i.res = res; i.lo = lo; i.rdata = rdata; i.d = d; i.hold = hold;
        return i;
    endfunction

    function automatic instr_t mk_rand();
        logic [5:0] ops [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        instr_t i;
        int kind;
        kind = $urandom_range(0, 3);
        i = mk(($urandom & 32'h0FFF_FFFC) | 32'h4000_0000, 1'b0, 4'd0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom), 6'd0, $urandom, 2'($urandom), $urandom, 0, 0);
        if (kind == 1) begin
            i.en = 1'b1; i.wen = 4'($urandom_range(1, 15)); i.op = OP_SW; i.sel = 1'b0; i.we = 1'b0;
        end else if (kind >= 2) begin
            i.en = 1'b1;
            i.op = ops[$urandom_range(0, 4)];
            i.sel = ($urandom_range(0, 7) != 0);
            i.d = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
            i.hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        end
        return i;
    endfunction

    // Monitor: counts stall-request cycles and checks each instruction as it leaves.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (m_if.stallreq_mem) begin
                stall_cnt++;
                chk("fwd_we_during_wait", 70'(m_if.mem_to_rf_bus[37]), 70'd0);
            end
            if (!m_if.stall[4] && m_if.mem_to_wb_bus[69:38] != 32'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", m_if.mem_to_wb_bus, 70'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_bus", m_if.mem_to_wb_bus, e.wb);
                    chk("rf_bus", 70'(m_if.mem_to_rf_bus), 70'(e.wb[37:0]));
                    chk("mem_adel", 70'(m_if.mem_adel), 70'(e.adel));
                    chk("mem_timeout", 70'(m_if.mem_timeout), 70'(e.tmo));
                    chk("stall_cycles", 70'(stall_cnt), 70'(e.nstall));
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        instr_t cur;
        bit     cur_v = 0;
        bit     cur_resp = 0;
        bit     cur_ld;
        int     age = 0;
        logic [5:0] ext;

        rst = 1'b0;
        m_if.stall = 6'd0;
        m_if.ex_to_mem_bus = {$urandom, $urandom, 18'($urandom)};
        m_if.ex_addr_lo = 2'd3;
        m_if.data_sram_rdata = $urandom;
        m_if.data_sram_rvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #3;
            chk("reset_wb_bus", m_if.mem_to_wb_bus, 70'd0);
            chk("reset_rf_bus", 70'(m_if.mem_to_rf_bus), 70'd0);
            chk("reset_stallreq", 70'(m_if.stallreq_mem), 70'd0);
            chk("reset_adel", 70'(m_if.mem_adel), 70'd0);
            chk("reset_timeout", 70'(m_if.mem_timeout), 70'd0);
            #4;
        end
        m_if.ex_to_mem_bus = '0;
        m_if.data_sram_rvalid = 1'b0;
        #4 rst = 1'b1;
        @(posedge clk); #1;

        pend.push_back(mk(32'hBFC00010, 0, 4'd0, 0, 1, 5'd5, 6'd0, 32'h1234, 2'd0, 32'd0, 0, 0));
        pend.push_back(mk(32'hBFC00014, 1, 4'd0, 1, 1, 5'd6, OP_LW, 32'h1000, 2'd0, 32'hDEADBEEF, 3, 0));
        pend.push_back(mk(32'hBFC00018, 1, 4'd0, 1, 1, 5'd7, OP_LB, 32'h1003, 2'd3, 32'h80FF7F01, 1, 0));
        pend.push_back(mk(32'hBFC0001C, 1, 4'd0, 1, 1, 5'd8, OP_LBU, 32'h1003, 2'd3, 32'h80FF7F01, 0, 0));
        pend.push_back(mk(32'hBFC00020, 1, 4'd0, 1, 1, 5'd9, OP_LH, 32'h1002, 2'd2, 32'h80FF7F01, 2, 0));
        pend.push_back(mk(32'hBFC00024, 1, 4'd0, 1, 1, 5'd10, OP_LW, 32'h1004, 2'd0, 32'hCAFEF00D, 1, 4));
        pend.push_back(mk(32'hBFC00028, 1, 4'd0, 1, 1, 5'd11, OP_LW, 32'h1006, 2'd2, 32'h12345678, 2, 0));
        pend.push_back(mk(32'hBFC0002C, 1, 4'd0, 1, 1, 5'd12, OP_LW, 32'h1008, 2'd0, 32'h55AA55AA, 99, 0));
        for (int n = 0; n < 150; n++) pend.push_back(mk_rand());

        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (pend.size() == 0 && sb.size() == 0) break;
            ext = 6'd0;
            if (cur_v && age < cur.hold) ext = ST_HOLD;
            else if ($urandom_range(0, 4) == 0) ext = $urandom_range(0, 1) ? ST_HOLD : ST_BUB;
            cur_ld = cur_v && m_is_load(cur);
            m_if.data_sram_rvalid = 1'b0;
            m_if.data_sram_rdata = $urandom;
            if (cur_ld && !cur_resp && age == cur.d) begin
                m_if.data_sram_rvalid = 1'b1;
                m_if.data_sram_rdata = cur.rdata;
                cur_resp = 1;
            end else if (!(cur_ld && !cur_resp && age < WAIT_MAX) && $urandom_range(0, 5) == 0) begin
                m_if.data_sram_rvalid = 1'b1;
            end
            m_if.ex_to_mem_bus = (pend.size() > 0) ? pack(pend[0]) : '0;
            m_if.ex_addr_lo = (pend.size() > 0) ? pend[0].lo : 2'd0;
            #1;
            m_if.stall = m_if.stallreq_mem ? ST_HOLD : ext;
            if (!m_if.stall[3]) begin
                cur_v = pend.size() > 0;
                if (cur_v) begin
                    exp_t e;
                    cur = pend.pop_front();
                    e = m_expect(cur);
                    if (m_is_load(cur) && cur.d >= WAIT_MAX) sb_tmo = 1'b1;
                    e.tmo = sb_tmo;
                    sb.push_back(e);
                end
                age = 0;
                cur_resp = 0;
            end else if (!m_if.stall[4]) begin
                cur_v = 0;
            end else begin
                age++;
            end
            @(posedge clk); #1;
        end
        if (pend.size() != 0 || sb.size() != 0)
            chk("cycle_budget_left", 70'(pend.size() + sb.size()), 70'd0);

        // Reset in the middle of an outstanding load.
        m_if.data_sram_rvalid = 1'b0;
        m_if.ex_to_mem_bus = pack(mk(32'h80000100, 1, 4'd0, 1, 1, 5'd3, OP_LW, 32'h2000, 2'd0, 32'd0, 99, 0));
        m_if.ex_addr_lo = 2'd0;
        m_if.stall = 6'd0;
        @(posedge clk); #1;
        m_if.ex_to_mem_bus = '0;
        m_if.stall = ST_HOLD;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("stallreq_mid_wait", 70'(m_if.stallreq_mem), 70'd1);
        chk("timeout_sticky", 70'(m_if.mem_timeout), 70'(sb_tmo));
        #1 rst = 1'b0;
        #1;
        chk("midwait_reset_wb_bus", m_if.mem_to_wb_bus, 70'd0);
        chk("midwait_reset_rf_bus", 70'(m_if.mem_to_rf_bus), 70'd0);
        chk("midwait_reset_stallreq", 70'(m_if.stallreq_mem), 70'd0);
        chk("midwait_reset_timeout", 70'(m_if.mem_timeout), 70'd0);
        m_if.stall = 6'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_stallreq", 70'(m_if.stallreq_mem), 70'd0);
        chk("post_reset_timeout", 70'(m_if.mem_timeout), 70'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
